// File: rtl/stopwatch_pkg.sv
// Shared types, defaults and elaboration-time helpers for the stopwatch digit chain.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } run_state_t;

  localparam int unsigned DEF_NUM_DIGITS = 4;
  localparam int unsigned DEF_DIGIT_W    = 4;
  // Moduli for MM:SS, top digit in the MSB slice.
  localparam logic [15:0] DEFAULT_DIGIT_MOD = {4'd6, 4'd10, 4'd6, 4'd10};
  // Widest packed modulus vector the slice helper accepts.
  localparam int unsigned MOD_PACK_W = 64;

  // Width of a digit index; never zero so single-digit chains still elaborate.
  function automatic int unsigned sel_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Modulus of digit idx; an all-zero slice encodes the full 2**w range.
  function automatic int unsigned digit_mod(input logic [MOD_PACK_W-1:0] packed_mod,
                                            input int unsigned idx,
                                            input int unsigned w);
    logic [MOD_PACK_W-1:0] mask;
    int unsigned raw;
    mask = (MOD_PACK_W'(1) << w) - MOD_PACK_W'(1);
    raw  = 32'((packed_mod >> (idx * w)) & mask);
    return (raw == 0) ? (32'd1 << w) : raw;
  endfunction

endpackage

// File: rtl/stopwatch_digit_chain_if.sv
// Control/status bundle between the stopwatch top level and the digit chain.
interface stopwatch_digit_chain_if #(
  parameter int unsigned NUM_DIGITS = stopwatch_pkg::DEF_NUM_DIGITS,
  parameter int unsigned DIGIT_W    = stopwatch_pkg::DEF_DIGIT_W
) ();
  localparam int unsigned SEL_W = stopwatch_pkg::sel_width(NUM_DIGITS);

  logic                          tick;
  logic                          start;
  logic                          stop;
  logic                          clear;
  logic                          ups;
  logic                          load;
  logic [NUM_DIGITS*DIGIT_W-1:0] load_val;
  logic                          adj_inc;
  logic                          adj_dec;
  logic [SEL_W-1:0]              adj_sel;
  logic [NUM_DIGITS*DIGIT_W-1:0] digits;
  logic                          running;
  logic                          done;
  logic                          carry_out;

  modport master (
    output tick, start, stop, clear, ups, load, load_val, adj_inc, adj_dec, adj_sel,
    input  digits, running, done, carry_out
  );

  modport slave (
    input  tick, start, stop, clear, ups, load, load_val, adj_inc, adj_dec, adj_sel,
    output digits, running, done, carry_out
  );
endinterface

// File: rtl/stopwatch_digit.sv
// One modulo-MOD counter digit with clamped preset, local adjust and a ripple wrap flag.
module stopwatch_digit #(
  parameter int unsigned DIGIT_W = 4,
  parameter int unsigned MOD     = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               step,
  input  logic               ups,
  input  logic               clear,
  input  logic               load,
  input  logic [DIGIT_W-1:0] load_val,
  input  logic               adj_inc,
  input  logic               adj_dec,
  output logic [DIGIT_W-1:0] value,
  output logic               wrap_c,
  output logic               at_zero_c,
  output logic               at_max_c
);
  localparam int unsigned       EXT_W   = DIGIT_W + 1;
  localparam logic [DIGIT_W-1:0] MAX_V  = DIGIT_W'(MOD - 1);
  localparam logic [EXT_W-1:0]  MOD_EXT = EXT_W'(MOD);

  logic [DIGIT_W-1:0] inc_c;
  logic [DIGIT_W-1:0] dec_c;
  logic [DIGIT_W-1:0] load_c;

  // Neighbour values, clamp and the wrap flag that steps the next digit.
  always_comb begin
    at_zero_c = (value == '0);
    at_max_c  = (value == MAX_V);
    inc_c     = at_max_c ? '0 : value + DIGIT_W'(1);
    dec_c     = at_zero_c ? MAX_V : value - DIGIT_W'(1);
    load_c    = ({1'b0, load_val} >= MOD_EXT) ? MAX_V : load_val;
    wrap_c    = step && (ups ? at_max_c : at_zero_c);
  end

  // Digit register: clear > load > adjust > step; inc+dec together holds.
  always_ff @(posedge clk) begin
    if (!reset) begin
      value <= '0;
    end else if (clear) begin
      value <= '0;
    end else if (load) begin
      value <= load_c;
    end else if (adj_inc && !adj_dec) begin
      value <= inc_c;
    end else if (adj_dec && !adj_inc) begin
      value <= dec_c;
    end else if (step) begin
      value <= ups ? inc_c : dec_c;
    end
  end
endmodule

// File: rtl/stopwatch_digit_chain.sv
// Cascaded up/down time counter: run FSM, command priority, terminal detection, pulse outputs.
module stopwatch_digit_chain
  import stopwatch_pkg::*;
#(
  parameter int unsigned                   NUM_DIGITS = DEF_NUM_DIGITS,
  parameter int unsigned                   DIGIT_W    = DEF_DIGIT_W,
  parameter logic [NUM_DIGITS*DIGIT_W-1:0] DIGIT_MOD  = (NUM_DIGITS*DIGIT_W)'(DEFAULT_DIGIT_MOD),
  parameter bit                            WRAP_UP    = 1'b1
) (
  input logic                    clk,
  input logic                    reset,
  stopwatch_digit_chain_if.slave bus
);
  localparam int unsigned         BUS_W     = NUM_DIGITS * DIGIT_W;
  localparam int unsigned         SEL_W     = sel_width(NUM_DIGITS);
  localparam int unsigned         MOD0      = digit_mod(MOD_PACK_W'(DIGIT_MOD), 0, DIGIT_W);
  localparam logic [DIGIT_W-1:0]  NEAR_MAX0 = DIGIT_W'(MOD0 - 2);
  localparam logic [NUM_DIGITS-1:0] LSD_MASK = NUM_DIGITS'(1);

  run_state_t            state_q, state_d;
  logic                  done_d, carry_d;
  logic                  running_q, done_q, carry_q;
  logic [NUM_DIGITS-1:0] at_zero_v, at_max_v;
  logic [BUS_W-1:0]      digits_v;
  logic                  all_zero_c, all_max_c, hold_c, reach_c;
  logic                  count_step_c, load_en_c, adj_en_c, msd_wrap_c;

  // Terminal detection and command qualification for the current state.
  always_comb begin
    all_zero_c   = &at_zero_v;
    all_max_c    = &at_max_v;
    // Already at the terminal value: a tick (or a start) must not move the digits.
    hold_c       = bus.ups ? (!WRAP_UP && all_max_c) : all_zero_c;
    // One step away: only digit 0 moves, so this tick lands on the terminal value.
    reach_c      = bus.ups
                   ? (!WRAP_UP && (&(at_max_v | LSD_MASK)) && (digits_v[DIGIT_W-1:0] == NEAR_MAX0))
                   : ((&(at_zero_v | LSD_MASK)) && (digits_v[DIGIT_W-1:0] == DIGIT_W'(1)));
    count_step_c = (state_q == RUN) && bus.tick && !bus.clear && !hold_c;
    load_en_c    = bus.load && !bus.clear && (state_q != RUN);
    adj_en_c     = ((state_q == IDLE) || (state_q == PAUSE)) && !bus.clear && !bus.load
                   && (bus.adj_inc ^ bus.adj_dec) && (32'(bus.adj_sel) < NUM_DIGITS);
  end

  // Digit chain; each digit steps on the wrap of the one below it.
  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_dig
    localparam int unsigned MOD_K = digit_mod(MOD_PACK_W'(DIGIT_MOD), k, DIGIT_W);
    logic               step_c, wrap_c, zero_c, max_c;
    logic [DIGIT_W-1:0] value;

    if (k == 0) begin : g_lsd
      assign step_c = count_step_c;
    end else begin : g_upper
      assign step_c = g_dig[k-1].wrap_c;
    end

    stopwatch_digit #(
      .DIGIT_W (DIGIT_W),
      .MOD     (MOD_K)
    ) u_digit (
      .clk       (clk),
      .reset     (reset),
      .step      (step_c),
      .ups       (bus.ups),
      .clear     (bus.clear),
      .load      (load_en_c),
      .load_val  (bus.load_val[k*DIGIT_W +: DIGIT_W]),
      .adj_inc   (adj_en_c && bus.adj_inc && (bus.adj_sel == SEL_W'(k))),
      .adj_dec   (adj_en_c && bus.adj_dec && (bus.adj_sel == SEL_W'(k))),
      .value     (value),
      .wrap_c    (wrap_c),
      .at_zero_c (zero_c),
      .at_max_c  (max_c)
    );

    assign digits_v[k*DIGIT_W +: DIGIT_W] = value;
    assign at_zero_v[k] = zero_c;
    assign at_max_v[k]  = max_c;
  end

  assign msd_wrap_c = g_dig[NUM_DIGITS-1].wrap_c;

  // Run FSM next state and pulse requests.
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    carry_d = 1'b0;
    if (bus.clear) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE, PAUSE: begin
          if (!bus.load && bus.start && !bus.stop) begin
            if (hold_c) begin
              state_d = DONE;
              done_d  = 1'b1;
            end else begin
              state_d = RUN;
            end
          end
        end
        RUN: begin
          state_d = bus.stop ? PAUSE : RUN;
          if (bus.tick) begin
            if (hold_c || reach_c) begin
              state_d = DONE;
              done_d  = 1'b1;
            end
            carry_d = msd_wrap_c && bus.ups;
          end
        end
        DONE: begin
          if (bus.load) state_d = PAUSE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and registered status outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      carry_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      running_q <= (state_d == RUN);
      done_q    <= done_d;
      carry_q   <= carry_d;
    end
  end

  assign bus.digits    = digits_v;
  assign bus.running   = running_q;
  assign bus.done      = done_q;
  assign bus.carry_out = carry_q;
endmodule

// File: tb/tb_stopwatch_digit_chain.sv
// Bench: MM:SS wrapping instance and 4-digit decimal saturating instance against an integer-count model.
module tb_stopwatch_digit_chain;
  localparam int ND = 4;
  localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_DONE = 3;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic tick = 0, start = 0, stop = 0, clear = 0, ups = 1, load = 0, adj_inc = 0, adj_dec = 0;
  logic [15:0] load_val = '0;
  logic [1:0]  adj_sel = '0;

  always #5 clk = ~clk;

  stopwatch_digit_chain_if #(.NUM_DIGITS(4), .DIGIT_W(4)) if0 ();
  stopwatch_digit_chain_if #(.NUM_DIGITS(4), .DIGIT_W(4)) if1 ();

  assign if0.tick = tick;       assign if1.tick = tick;
  assign if0.start = start;     assign if1.start = start;
  assign if0.stop = stop;       assign if1.stop = stop;
  assign if0.clear = clear;     assign if1.clear = clear;
  assign if0.ups = ups;         assign if1.ups = ups;
  assign if0.load = load;       assign if1.load = load;
  assign if0.load_val = load_val; assign if1.load_val = load_val;
  assign if0.adj_inc = adj_inc; assign if1.adj_inc = adj_inc;
  assign if0.adj_dec = adj_dec; assign if1.adj_dec = adj_dec;
  assign if0.adj_sel = adj_sel; assign if1.adj_sel = adj_sel;

  stopwatch_digit_chain #(.NUM_DIGITS(4), .DIGIT_W(4), .DIGIT_MOD(16'h6A6A), .WRAP_UP(1'b1))
    dut0 (.clk(clk), .reset(reset), .bus(if0));
  stopwatch_digit_chain #(.NUM_DIGITS(4), .DIGIT_W(4), .DIGIT_MOD(16'hAAAA), .WRAP_UP(1'b0))
    dut1 (.clk(clk), .reset(reset), .bus(if1));

  // Model: the count is one integer in a mixed-radix number system.
  int mods [2][ND] = '{'{10, 6, 10, 6}, '{10, 10, 10, 10}};
  bit wrapf [2] = '{1'b1, 1'b0};
  int cnt [2] = '{0, 0};
  int st [2] = '{S_IDLE, S_IDLE};
  bit m_done [2] = '{1'b0, 1'b0};
  bit m_carry [2] = '{1'b0, 1'b0};

  int n_chk = 0, n_fail = 0;
  bit chk_en = 1'b1;

  function automatic int weight(int i, int k);
    int w = 1;
    for (int j = 0; j < k; j++) w = w * mods[i][j];
    return w;
  endfunction

  function automatic int dig_of(int i, int c, int k);
    return (c / weight(i, k)) % mods[i][k];
  endfunction

  function automatic logic [15:0] to_dig(int i, int c);
    logic [15:0] d = '0;
    for (int k = 0; k < ND; k++) d[k*4 +: 4] = 4'(dig_of(i, c, k));
    return d;
  endfunction

  function automatic int from_load(int i, logic [15:0] v);
    int c = 0;
    int s;
    for (int k = 0; k < ND; k++) begin
      s = int'(v[k*4 +: 4]);
      if (s > mods[i][k] - 1) s = mods[i][k] - 1;
      c = c + s * weight(i, k);
    end
    return c;
  endfunction

  function automatic logic [15:0] dut_dig(int i);
    return (i == 0) ? if0.digits : if1.digits;
  endfunction

  function automatic logic [2:0] dut_flags(int i);
    return (i == 0) ? {if0.running, if0.done, if0.carry_out} : {if1.running, if1.done, if1.carry_out};
  endfunction

  task automatic check(string name, int i, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s inst%0d @%0t: got %0h expected %0h", name, i, $time, act, exp);
    end
  endtask

  // Advance the model of instance i by one clock edge using the applied inputs.
  task automatic model_clk(int i);
    int tot = weight(i, ND);
    bit term_now;
    int d, m, nd;
    m_done[i]  = 1'b0;
    m_carry[i] = 1'b0;
    if (!reset || clear) begin
      cnt[i] = 0;
      st[i]  = S_IDLE;
    end else if (load && st[i] != S_RUN) begin
      cnt[i] = from_load(i, load_val);
      if (st[i] == S_DONE) st[i] = S_PAUSE;
    end else if (st[i] == S_IDLE || st[i] == S_PAUSE) begin
      term_now = ups ? (!wrapf[i] && cnt[i] == tot - 1) : (cnt[i] == 0);
      if (adj_inc != adj_dec && int'(adj_sel) < ND) begin
        d  = dig_of(i, cnt[i], int'(adj_sel));
        m  = mods[i][adj_sel];
        nd = adj_inc ? (d + 1) % m : (d + m - 1) % m;
        cnt[i] = cnt[i] + (nd - d) * weight(i, int'(adj_sel));
      end
      if (start && !stop) begin
        if (term_now) begin
          st[i] = S_DONE;
          m_done[i] = 1'b1;
        end else begin
          st[i] = S_RUN;
        end
      end
    end else if (st[i] == S_RUN) begin
      st[i] = stop ? S_PAUSE : S_RUN;
      if (tick) begin
        if (ups) begin
          if (cnt[i] == tot - 1) begin
            if (wrapf[i]) begin
              cnt[i] = 0;
              m_carry[i] = 1'b1;
            end else begin
              st[i] = S_DONE;
              m_done[i] = 1'b1;
            end
          end else begin
            cnt[i]++;
            if (!wrapf[i] && cnt[i] == tot - 1) begin
              st[i] = S_DONE;
              m_done[i] = 1'b1;
            end
          end
        end else begin
          if (cnt[i] != 0) cnt[i]--;
          if (cnt[i] == 0) begin
            st[i] = S_DONE;
            m_done[i] = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_clk(0);
    model_clk(1);
    @(negedge clk);
    tick = 0; start = 0; stop = 0; clear = 0; load = 0; adj_inc = 0; adj_dec = 0;
  endtask

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        check("digits", i, 32'(dut_dig(i)), 32'(to_dig(i, cnt[i])));
        check("running", i, 32'(dut_flags(i)[2]), 32'(st[i] == S_RUN));
        check("done", i, 32'(dut_flags(i)[1]), 32'(m_done[i]));
        check("carry_out", i, 32'(dut_flags(i)[0]), 32'(m_carry[i]));
      end
    end
  end

  initial begin
    int r;
    // Reset state
    step(); step();
    check("rst_digits", 0, 32'(if0.digits), 32'h0);
    check("rst_flags", 0, 32'(dut_flags(0)), 32'h0);
    reset = 1'b1;

    // Up with wrap: 59:58 -> 59:59 -> 00:00 with carry_out
    ups = 1; clear = 1; step();
    load = 1; load_val = 16'h5958; step();
    check("t1_load", 0, 32'(if0.digits), 32'h5958);
    start = 1; step();
    check("t1_run", 0, 32'(if0.running), 32'h1);
    tick = 1; step();
    check("t1_5959", 0, 32'(if0.digits), 32'h5959);
    check("t1_nocarry", 0, 32'(if0.carry_out), 32'h0);
    tick = 1; step();
    check("t1_wrap", 0, 32'(if0.digits), 32'h0000);
    check("t1_carry", 0, 32'(if0.carry_out), 32'h1);
    check("t1_still_run", 0, 32'(if0.running), 32'h1);
    step();
    check("t1_carry_pulse", 0, 32'(if0.carry_out), 32'h0);

    // Down count to zero
    stop = 1; step();
    check("t2_pause", 0, 32'(if0.running), 32'h0);
    ups = 0; load = 1; load_val = 16'h0100; step();
    start = 1; step();
    tick = 1; step();
    check("t2_0059", 0, 32'(if0.digits), 32'h0059);
    repeat (58) begin tick = 1; step(); end
    check("t2_0001", 0, 32'(if0.digits), 32'h0001);
    check("t2_nodone", 0, 32'(if0.done), 32'h0);
    tick = 1; step();
    check("t2_zero", 0, 32'(if0.digits), 32'h0000);
    check("t2_done", 0, 32'(if0.done), 32'h1);
    check("t2_stopped", 0, 32'(if0.running), 32'h0);
    tick = 1; start = 1; step();
    check("t2_done_pulse", 0, 32'(if0.done), 32'h0);
    check("t2_stays_done", 0, 32'(if0.running), 32'h0);
    check("t2_hold", 0, 32'(if0.digits), 32'h0000);

    // Adjust in PAUSE (load from DONE lands in PAUSE)
    load = 1; load_val = 16'h0009; step();
    check("t3_load", 0, 32'(if0.digits), 32'h0009);
    adj_sel = 2'd0; adj_inc = 1; step();
    check("t3_inc_wrap", 0, 32'(if0.digits), 32'h0000);
    adj_sel = 2'd3; adj_dec = 1; step();
    check("t3_dec_top", 0, 32'(if0.digits), 32'h5000);
    ups = 1; start = 1; step();
    check("t3_run", 0, 32'(if0.running), 32'h1);
    adj_sel = 2'd0; adj_inc = 1; step();
    check("t3_adj_in_run", 0, 32'(if0.digits), 32'h5000);

    // Priority
    clear = 1; load = 1; load_val = 16'h1234; tick = 1; step();
    check("t4_clear_wins", 0, 32'(if0.digits), 32'h0000);
    check("t4_idle", 0, 32'(if0.running), 32'h0);
    start = 1; step();
    check("t4_run", 0, 32'(if0.running), 32'h1);
    start = 1; stop = 1; step();
    check("t4_stop_wins", 0, 32'(if0.running), 32'h0);

    // Load clamp and multi-digit ripple
    clear = 1; step();
    load = 1; load_val = 16'h0090; step();
    check("t5_clamp", 0, 32'(if0.digits), 32'h0050);
    check("t5_noclamp", 1, 32'(if1.digits), 32'h0090);
    load = 1; load_val = 16'h0999; step();
    check("t5_load0", 0, 32'(if0.digits), 32'h0959);
    ups = 1; start = 1; step();
    tick = 1; step();
    check("t5_ripple", 0, 32'(if0.digits), 32'h1000);
    check("t5_ripple", 1, 32'(if1.digits), 32'h1000);

    // Saturating up count
    stop = 1; step();
    load = 1; load_val = 16'h9998; step();
    start = 1; step();
    tick = 1; step();
    check("sat_max", 1, 32'(if1.digits), 32'h9999);
    check("sat_done", 1, 32'(if1.done), 32'h1);
    check("sat_stopped", 1, 32'(if1.running), 32'h0);

    // Start at zero while counting down
    clear = 1; step();
    ups = 0; start = 1; step();
    check("z_done", 0, 32'(if0.done), 32'h1);
    check("z_state", 0, 32'(if0.running), 32'h0);

    // Reset mid-run at 12:34
    clear = 1; step();
    ups = 1; load = 1; load_val = 16'h1234; step();
    start = 1; step();
    check("t6_run", 0, 32'(if0.running), 32'h1);
    reset = 0; tick = 1; step();
    check("t6_digits", 0, 32'(if0.digits), 32'h0000);
    check("t6_flags", 0, 32'(dut_flags(0)), 32'h0);
    reset = 1;

    // Randomised traffic
    for (int c = 0; c < 4000; c++) begin
      reset   = ($urandom_range(0, 199) != 0);
      tick    = 1'($urandom_range(0, 1));
      start   = ($urandom_range(0, 9) == 0);
      stop    = ($urandom_range(0, 19) == 0);
      clear   = ($urandom_range(0, 79) == 0);
      load    = ($urandom_range(0, 19) == 0);
      adj_inc = ($urandom_range(0, 7) == 0);
      adj_dec = ($urandom_range(0, 7) == 0);
      adj_sel = 2'($urandom_range(0, 3));
      r = $urandom_range(0, 3);
      case (r)
        0: load_val = 16'($urandom_range(0, 3));
        1: load_val = 16'h5959 - 16'($urandom_range(0, 3));
        2: load_val = 16'h9999 - 16'($urandom_range(0, 3));
        default: load_val = 16'($urandom);
      endcase
      if ($urandom_range(0, 15) == 0) ups = ~ups;
      step();
    end

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
